lpif_txrx_asym_slave_link: RTL and testbench

Parametrised LPIF logic-link slave datapath that replaces the fixed two-channel, 42-bit slave concat/auto-sync pairing with a generic NUM_CH x PHY_W layout. It sequences TX bring-up with programmable delays and persistent strobe/marker user bits. It packs upstream LPIF words onto PHY channels and unpacks downstream PHY words. It also adds RX-side alignment qualification and marker/strobe error monitoring, which the previous generation lacked. It sits between the LPIF user-interface name block and the AIB PHY channels, single clock domain.

---
 rtl/lpif_txrx_asym_slave_link_if.sv | 39 +++
 rtl/lpif_txrx_asym_slave_link.sv | 223 ++++++++++++++++++++++
 tb/tb_lpif_txrx_asym_slave_link.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpif_txrx_asym_slave_link_if.sv
// LPIF logic-link slave bundle: everything between the link block and its
// user/PHY neighbours except clock and reset.
//   master : drives enables, delays, tx_data, rx_phy; observes the rest
//   slave  : the link datapath itself
interface lpif_txrx_asym_slave_link_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned PHY_W  = 40,
  parameter int unsigned DATA_W = 42
);
  logic                      tx_online;
  logic                      rx_online;
  logic [15:0]               delay_x_value;
  logic [15:0]               delay_y_value;
  logic [15:0]               delay_z_value;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;
  logic [NUM_CH*PHY_W-1:0]   tx_phy;
  logic [NUM_CH*PHY_W-1:0]   rx_phy;
  logic [DATA_W-1:0]         rx_data;
  logic                      rx_valid;
  logic                      tx_online_delay;
  logic                      rx_online_delay;
  logic                      rx_align_err;
  logic [31:0]               debug_status;

  modport master (
    output tx_online, rx_online, delay_x_value, delay_y_value, delay_z_value,
           tx_data, rx_phy,
    input  tx_ready, tx_phy, rx_data, rx_valid, tx_online_delay,
           rx_online_delay, rx_align_err, debug_status
  );

  modport slave (
    input  tx_online, rx_online, delay_x_value, delay_y_value, delay_z_value,
           tx_data, rx_phy,
    output tx_ready, tx_phy, rx_data, rx_valid, tx_online_delay,
           rx_online_delay, rx_align_err, debug_status
  );
endinterface

// File: rtl/lpif_txrx_asym_slave_link.sv
// Generic NUM_CH x PHY_W LPIF logic-link slave datapath.
// TX: bring-up sequencer (idle / wait X / strobe+marker for Y / online) and
//     packing of tx_data into the non-STB/MRK bits of each channel word.
// RX: wait Z, then require ALIGN_CNT consecutive STB/MRK-good words before
//     going online; unpacks payload and flags strobe/marker errors.
// Ports:
//   clk_wr   - single clock, rising edge
//   rst_wr_n - asynchronous active-low reset
//   lnk      - slave modport of lpif_txrx_asym_slave_link_if
module lpif_txrx_asym_slave_link #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned PHY_W     = 40,
  parameter int unsigned DATA_W    = 42,
  parameter int unsigned STB_BIT   = 1,
  parameter int unsigned MRK_BIT   = 39,
  parameter int unsigned ALIGN_CNT = 4
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  lpif_txrx_asym_slave_link_if.slave    lnk
);

  localparam int unsigned BUS_W = NUM_CH * PHY_W;
  localparam int unsigned DIW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned BIW   = (BUS_W > 1) ? $clog2(BUS_W) : 1;

  typedef enum logic [1:0] {
    T_IDLE   = 2'd0,
    T_WAIT_X = 2'd1,
    T_WAIT_Y = 2'd2,
    T_ONLINE = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_WAIT_Z = 2'd1,
    R_ALIGN  = 2'd2,
    R_ONLINE = 2'd3
  } rx_state_e;

  // STB and MRK set on every channel.
  function automatic logic [BUS_W-1:0] marks();
    logic [BUS_W-1:0] m;
    m = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      m[BIW'(c*PHY_W + STB_BIT)] = 1'b1;
      m[BIW'(c*PHY_W + MRK_BIT)] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [BUS_W-1:0] MARKS = marks();

  // Payload slots walk each channel in ascending bit order skipping STB/MRK,
  // channel 0 first; slots beyond DATA_W stay 0.
  function automatic logic [BUS_W-1:0] pack(input logic [DATA_W-1:0] d);
    logic [BUS_W-1:0] p;
    int unsigned      s;
    p = '0;
    s = 0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned b = 0; b < PHY_W; b++) begin
        if (b != STB_BIT && b != MRK_BIT) begin
          if (s < DATA_W) p[BIW'(c*PHY_W + b)] = d[DIW'(s)];
          s++;
        end
      end
    end
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] unpack(input logic [BUS_W-1:0] p);
    logic [DATA_W-1:0] d;
    int unsigned       s;
    d = '0;
    s = 0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned b = 0; b < PHY_W; b++) begin
        if (b != STB_BIT && b != MRK_BIT) begin
          if (s < DATA_W) d[DIW'(s)] = p[BIW'(c*PHY_W + b)];
          s++;
        end
      end
    end
    return d;
  endfunction

  // ---------------------------------------------------------------- TX ----
  tx_state_e         tx_st_q;
  logic [15:0]       tx_cnt_q;
  logic [BUS_W-1:0]  tx_phy_q;
  logic              tx_ready_q;

  // Word outputs follow the state held at the sampling edge, so the first
  // STB/MRK word trails entry into T_WAIT_Y by one cycle.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_st_q    <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_phy_q   <= '0;
      tx_ready_q <= 1'b0;
    end else if (!lnk.tx_online) begin
      tx_st_q    <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_phy_q   <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      tx_phy_q   <= '0;
      tx_ready_q <= 1'b0;
      case (tx_st_q)
        T_IDLE: begin
          tx_st_q  <= T_WAIT_X;
          tx_cnt_q <= '0;
        end
        T_WAIT_X: begin
          if (tx_cnt_q == lnk.delay_x_value) begin
            tx_st_q  <= T_WAIT_Y;
            tx_cnt_q <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        T_WAIT_Y: begin
          tx_phy_q <= MARKS;
          if (tx_cnt_q == lnk.delay_y_value) begin
            tx_st_q  <= T_ONLINE;
            tx_cnt_q <= '0;
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        T_ONLINE: begin
          tx_phy_q   <= MARKS | pack(lnk.tx_data);
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX ----
  rx_state_e          rx_st_q;
  logic [15:0]        rx_cnt_q;
  logic [3:0]         good_cnt_q;
  logic [7:0]         err_cnt_q;
  logic               align_err_q;
  logic               rx_valid_q;
  logic               rx_on_dly_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic               word_good;

  assign word_good = ((lnk.rx_phy & MARKS) == MARKS);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_st_q     <= R_IDLE;
      rx_cnt_q    <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
      align_err_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_on_dly_q <= 1'b0;
      rx_data_q   <= '0;
    end else if (!lnk.rx_online) begin
      rx_st_q     <= R_IDLE;
      rx_cnt_q    <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
      align_err_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_on_dly_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      rx_on_dly_q <= 1'b0;
      case (rx_st_q)
        R_IDLE: begin
          rx_st_q  <= R_WAIT_Z;
          rx_cnt_q <= '0;
        end
        R_WAIT_Z: begin
          if (rx_cnt_q == lnk.delay_z_value) begin
            rx_st_q    <= R_ALIGN;
            rx_cnt_q   <= '0;
            good_cnt_q <= '0;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        R_ALIGN: begin
          if (word_good) begin
            good_cnt_q <= good_cnt_q + 4'd1;
            if (good_cnt_q == 4'(ALIGN_CNT - 1)) begin
              rx_st_q     <= R_ONLINE;
              rx_on_dly_q <= 1'b1;
            end
          end else begin
            good_cnt_q <= '0;
          end
        end
        R_ONLINE: begin
          rx_on_dly_q <= 1'b1;
          if (word_good) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= unpack(lnk.rx_phy);
          end else begin
            align_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign lnk.tx_phy          = tx_phy_q;
  assign lnk.tx_ready        = tx_ready_q;
  assign lnk.tx_online_delay = tx_ready_q;
  assign lnk.rx_data         = rx_data_q;
  assign lnk.rx_valid        = rx_valid_q;
  assign lnk.rx_online_delay = rx_on_dly_q;
  assign lnk.rx_align_err    = align_err_q;
  assign lnk.debug_status    = {8'h00, err_cnt_q, 2'b00, tx_ready_q, rx_on_dly_q,
                                tx_st_q, rx_st_q, 8'h00};

endmodule

// File: tb/tb_lpif_txrx_asym_slave_link.sv
module tb_lpif_txrx_asym_slave_link;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loop_en = 1'b0;
  logic [79:0] rx_drv = '0;

  int checks = 0;
  int errors = 0;

  logic [41:0] exp_q[$];

  lpif_txrx_asym_slave_link_if #(.NUM_CH(2), .PHY_W(40), .DATA_W(42)) lnk ();

  lpif_txrx_asym_slave_link #(
    .NUM_CH(2), .PHY_W(40), .DATA_W(42),
    .STB_BIT(1), .MRK_BIT(39), .ALIGN_CNT(4)
  ) dut (
    .clk_wr   (clk),
    .rst_wr_n (rst_n),
    .lnk      (lnk)
  );

  assign lnk.rx_phy = loop_en ? lnk.tx_phy : rx_drv;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference layout for STB=1, MRK=39, 2 x 40, 42-bit payload.
  function automatic logic [79:0] mk_word(input logic [41:0] d, input logic s0,
                                          input logic m0, input logic s1, input logic m1);
    logic [79:0] w;
    w        = '0;
    w[0]     = d[0];
    w[1]     = s0;
    w[38:2]  = d[37:1];
    w[39]    = m0;
    w[40]    = d[38];
    w[41]    = s1;
    w[44:42] = d[41:39];
    w[79]    = m1;
    return w;
  endfunction

  function automatic logic [41:0] rnd42();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[41:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lnk.tx_online = 1'b0;
    lnk.rx_online = 1'b0;
    loop_en = 1'b0;
    rx_drv = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lnk.tx_online = 1'b0;
    lnk.rx_online = 1'b0;
    lnk.delay_x_value = 16'd0;
    lnk.delay_y_value = 16'd0;
    lnk.delay_z_value = 16'd0;
    lnk.tx_data = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (lnk.tx_phy !== 80'd0 || lnk.tx_ready !== 1'b0 || lnk.rx_valid !== 1'b0 ||
        lnk.rx_data !== 42'd0 || lnk.tx_online_delay !== 1'b0 ||
        lnk.rx_online_delay !== 1'b0 || lnk.rx_align_err !== 1'b0 ||
        lnk.debug_status !== 32'd0) begin
      $display("FAIL reset_outputs: tx_phy=%h ready=%b valid=%b dbg=%h required all zero",
               lnk.tx_phy, lnk.tx_ready, lnk.rx_valid, lnk.debug_status);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Assumes TX in T_IDLE with tx_online=1 before the next rising edge.
  task automatic check_tx_seq(input int x, input int y, input logic [41:0] d);
    logic [79:0] exp_phy;
    logic [1:0]  exp_st;
    logic        exp_rdy;
    for (int i = 1; i <= x + y + 6; i++) begin
      @(posedge clk);
      #1;
      exp_st  = (i <= x + 1) ? 2'd1 : (i <= x + y + 2) ? 2'd2 : 2'd3;
      exp_rdy = (i >= x + y + 4);
      exp_phy = (i <= x + 2) ? 80'd0 :
                (i <= x + y + 3) ? mk_word('0, 1'b1, 1'b1, 1'b1, 1'b1) :
                mk_word(d, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (lnk.tx_phy !== exp_phy || lnk.tx_ready !== exp_rdy ||
          lnk.debug_status[11:10] !== exp_st || lnk.debug_status[13] !== exp_rdy) begin
        $display("FAIL tx_seq cycle %0d: phy=%h ready=%b st=%0d required phy=%h ready=%b st=%0d",
                 i, lnk.tx_phy, lnk.tx_ready, lnk.debug_status[11:10], exp_phy, exp_rdy, exp_st);
        errors++;
      end
    end
  endtask

  task automatic test_tx_bringup();
    do_reset();
    lnk.delay_x_value = 16'd3;
    lnk.delay_y_value = 16'd2;
    lnk.tx_data = 42'h2AA_5555_AAAA;
    lnk.tx_online = 1'b1;
    check_tx_seq(3, 2, 42'h2AA_5555_AAAA);
  endtask

  // Continues from T_ONLINE: random words, 1-cycle pack latency, then drop.
  task automatic test_tx_payload();
    logic [79:0] got;
    logic [41:0] e;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lnk.tx_data = (i == 0) ? '1 : (i == 1) ? 42'd1 : rnd42();
      exp_q.push_back(lnk.tx_data);
      @(posedge clk);
      #1;
      got = lnk.tx_phy;
      e = exp_q.pop_front();
      checks++;
      if (got !== mk_word(e, 1'b1, 1'b1, 1'b1, 1'b1)) begin
        $display("FAIL tx_pack word %0d: got %h required %h", i, got,
                 mk_word(e, 1'b1, 1'b1, 1'b1, 1'b1));
        errors++;
      end
    end
    @(negedge clk);
    lnk.tx_online = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (lnk.tx_phy !== 80'd0 || lnk.tx_ready !== 1'b0 || lnk.debug_status[11:10] !== 2'd0) begin
      $display("FAIL tx_drop: phy=%h ready=%b st=%0d required 0/0/0",
               lnk.tx_phy, lnk.tx_ready, lnk.debug_status[11:10]);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lnk.delay_x_value = 16'd3;
    lnk.delay_y_value = 16'd6;
    lnk.tx_data = 42'h155_AAAA_5555;
    lnk.tx_online = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (lnk.debug_status[11:10] !== 2'd2 || lnk.tx_phy !== mk_word('0, 1'b1, 1'b1, 1'b1, 1'b1)) begin
      $display("FAIL pre_reset_wait_y: st=%0d phy=%h required st=2 marks-only",
               lnk.debug_status[11:10], lnk.tx_phy);
      errors++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (lnk.tx_phy !== 80'd0 || lnk.debug_status !== 32'd0) begin
      $display("FAIL async_reset: phy=%h dbg=%h required 0/0", lnk.tx_phy, lnk.debug_status);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_tx_seq(3, 6, 42'h155_AAAA_5555);
  endtask

  task automatic test_loopback();
    logic [41:0] e;
    int first_valid;
    int n_valid;
    logic have;
    do_reset();
    loop_en = 1'b1;
    lnk.delay_x_value = 16'd3;
    lnk.delay_y_value = 16'd2;
    lnk.delay_z_value = 16'd0;
    exp_q.delete();
    first_valid = 0;
    n_valid = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        lnk.tx_online = 1'b1;
        lnk.rx_online = 1'b1;
      end
      lnk.tx_data = rnd42();
      exp_q.push_back(lnk.tx_data);
      @(posedge clk);
      #1;
      have = 1'b0;
      e = '0;
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        have = 1'b1;
      end
      if (lnk.rx_valid === 1'b1) begin
        if (first_valid == 0) first_valid = i;
        n_valid++;
        checks++;
        if (!have || lnk.rx_data !== e) begin
          $display("FAIL loop_data cycle %0d: rx_data=%h required %h", i, lnk.rx_data, e);
          errors++;
        end
      end
    end
    checks++;
    if (first_valid != 11 || n_valid != 20) begin
      $display("FAIL loop_first_valid: first=%0d count=%0d required first=11 count=20",
               first_valid, n_valid);
      errors++;
    end
    @(negedge clk);
    lnk.tx_online = 1'b0;
    lnk.rx_online = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (lnk.rx_valid !== 1'b0 || lnk.rx_online_delay !== 1'b0 || lnk.debug_status[9:8] !== 2'd0) begin
      $display("FAIL rx_drop: valid=%b on_dly=%b st=%0d required 0/0/0",
               lnk.rx_valid, lnk.rx_online_delay, lnk.debug_status[9:8]);
      errors++;
    end
    loop_en = 1'b0;
  endtask

  task automatic drive_rx_word(input logic [79:0] w, input logic [1:0] exp_st, input string nm);
    @(negedge clk);
    rx_drv = w;
    @(posedge clk);
    #1;
    checks++;
    if (lnk.debug_status[9:8] !== exp_st || lnk.rx_valid !== 1'b0) begin
      $display("FAIL %s: rx_state=%0d valid=%b required state=%0d valid=0",
               nm, lnk.debug_status[9:8], lnk.rx_valid, exp_st);
      errors++;
    end
  endtask

  // Leaves RX in R_ONLINE with rx_online=1 for the error test.
  task automatic test_rx_align();
    logic [79:0] good;
    logic [79:0] bad;
    logic [41:0] e;
    do_reset();
    lnk.delay_z_value = 16'd0;
    good = mk_word(42'h0AB_CDEF_0123, 1'b1, 1'b1, 1'b1, 1'b1);
    bad  = mk_word(42'h0AB_CDEF_0123, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    rx_drv = bad;
    lnk.rx_online = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (lnk.debug_status[9:8] !== 2'd2) begin
      $display("FAIL rx_reach_align: state=%0d required 2", lnk.debug_status[9:8]);
      errors++;
    end
    for (int i = 0; i < 3; i++) drive_rx_word(good, 2'd2, "align_run1");
    drive_rx_word(bad, 2'd2, "align_bad");
    for (int i = 0; i < 3; i++) drive_rx_word(good, 2'd2, "align_run2");
    drive_rx_word(good, 2'd3, "align_enter_online");
    checks++;
    if (lnk.debug_status[23:16] !== 8'd0 || lnk.rx_align_err !== 1'b0 || lnk.rx_online_delay !== 1'b1) begin
      $display("FAIL align_err_clean: cnt=%0d err=%b on_dly=%b required 0/0/1",
               lnk.debug_status[23:16], lnk.rx_align_err, lnk.rx_online_delay);
      errors++;
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = rnd42();
      rx_drv = mk_word(e, 1'b1, 1'b1, 1'b1, 1'b1);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      if (lnk.rx_valid !== 1'b1) begin
        $display("FAIL rx_valid word %0d: got %b required 1", i, lnk.rx_valid);
        errors++;
      end else begin
        e = exp_q.pop_front();
        if (lnk.rx_data !== e) begin
          $display("FAIL rx_unpack word %0d: got %h required %h", i, lnk.rx_data, e);
          errors++;
        end
      end
    end
  endtask

  task automatic test_rx_errors();
    logic [41:0] last;
    last = lnk.rx_data;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      rx_drv = mk_word(rnd42(), 1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (lnk.rx_valid !== 1'b0 || lnk.rx_data !== last || lnk.rx_align_err !== 1'b1 ||
          lnk.debug_status[9:8] !== 2'd3 ||
          lnk.debug_status[23:16] !== ((i > 255) ? 8'd255 : 8'(i))) begin
        $display("FAIL rx_bad word %0d: valid=%b data=%h err=%b cnt=%0d st=%0d",
                 i, lnk.rx_valid, lnk.rx_data, lnk.rx_align_err,
                 lnk.debug_status[23:16], lnk.debug_status[9:8]);
        errors++;
      end
    end
    @(negedge clk);
    lnk.rx_online = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (lnk.rx_align_err !== 1'b0 || lnk.debug_status !== 32'd0 || lnk.rx_valid !== 1'b0) begin
      $display("FAIL rx_err_clear: err=%b dbg=%h valid=%b required 0/0/0",
               lnk.rx_align_err, lnk.debug_status, lnk.rx_valid);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_tx_bringup();
    test_tx_payload();
    test_reset_mid();
    test_loopback();
    test_rx_align();
    test_rx_errors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
